// File: rtl/countdown_core.sv
// countdown_core: keypad-driven DIGITS-wide BCD countdown with built-in tick prescaler.
// Optional pause/resume on the start key is enabled by defining COUNTDOWN_PAUSE_EN.
module countdown_core #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_num_valid,
  input  logic [3:0]            key_num,
  input  logic                  key_start,
  input  logic                  key_confirm,
  input  logic                  key_clear,
  output logic [4*DIGITS-1:0]   set_bcd,
  output logic [4*DIGITS-1:0]   rem_bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic [2:0]            state,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_PAUSE = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_CLEAR,
    K_CONFIRM,
    K_START,
    K_NUM
  } key_e;

  state_e        st;
  key_e          key;
  logic [PW-1:0] psc;
  logic          wrap;
  logic [W-1:0]  shifted;
  logic [W-1:0]  dec;

  function automatic logic [W-1:0] bcd_dec(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Only the highest-priority pulse is seen by the FSM.
  always_comb begin
    key = K_NONE;
    priority case (1'b1)
      key_clear:     key = K_CLEAR;
      key_confirm:   key = K_CONFIRM;
      key_start:     key = K_START;
      key_num_valid: key = K_NUM;
      default:       key = K_NONE;
    endcase
  end

  assign wrap    = (psc == PW'(TICK_DIV - 1));
  assign shifted = (set_bcd << 4) | W'(key_num);
  assign dec     = bcd_dec(rem_bcd);
  assign state   = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      set_bcd  <= '0;
      rem_bcd  <= '0;
      digit_en <= '0;
      done     <= 1'b0;
      psc      <= '0;
    end else begin
      done <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (key == K_START) begin
            st       <= S_ENTRY;
            set_bcd  <= '0;
            rem_bcd  <= '0;
            digit_en <= '1;
          end
        end
        S_ENTRY: begin
          unique case (key)
            K_CLEAR: set_bcd <= '0;
            K_CONFIRM: begin
              if (set_bcd != '0) begin
                rem_bcd <= set_bcd;
                psc     <= '0;
                st      <= S_RUN;
              end
            end
            K_NUM: begin
              if (key_num < 4'd10)
                set_bcd <= shifted;
            end
            default: ;
          endcase
        end
        S_RUN: begin
          if (key == K_CLEAR) begin
            st      <= S_ENTRY;
            set_bcd <= '0;
            rem_bcd <= '0;
          end
`ifdef COUNTDOWN_PAUSE_EN
          else if (key == K_START) begin
            st <= S_PAUSE;
          end
`endif
          else if (wrap) begin
            psc     <= '0;
            rem_bcd <= dec;
            if (dec == '0) begin
              st   <= S_DONE;
              done <= 1'b1;
            end
          end else begin
            psc <= psc + 1'b1;
          end
        end
        S_DONE: begin
          if (key == K_CLEAR) begin
            st       <= S_IDLE;
            set_bcd  <= '0;
            rem_bcd  <= '0;
            digit_en <= '0;
          end else if (key == K_START) begin
            st      <= S_ENTRY;
            set_bcd <= '0;
            rem_bcd <= '0;
          end
        end
`ifdef COUNTDOWN_PAUSE_EN
        S_PAUSE: begin
          if (key == K_CLEAR) begin
            st      <= S_ENTRY;
            set_bcd <= '0;
            rem_bcd <= '0;
          end else if (key == K_START) begin
            st <= S_RUN;
          end
        end
`endif
        default: begin
          st       <= S_IDLE;
          set_bcd  <= '0;
          rem_bcd  <= '0;
          digit_en <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_core.sv
// tb_countdown_core: integer-level model of the countdown plus directed key sequences.
// Build with COUNTDOWN_PAUSE_EN to exercise the pause variant.
module tb_countdown_core;

  localparam int D   = 2;
  localparam int TD  = 4;
  localparam int MOD = 100;
`ifdef COUNTDOWN_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_num_valid;
  logic [3:0]   key_num;
  logic         key_start;
  logic         key_confirm;
  logic         key_clear;
  logic [4*D-1:0] set_bcd;
  logic [4*D-1:0] rem_bcd;
  logic [D-1:0] digit_en;
  logic [2:0]   state;
  logic         done;

  int total = 0;
  int bad   = 0;

  countdown_core #(.DIGITS(D), .TICK_DIV(TD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_num_valid(key_num_valid),
    .key_num(key_num),
    .key_start(key_start),
    .key_confirm(key_confirm),
    .key_clear(key_clear),
    .set_bcd(set_bcd),
    .rem_bcd(rem_bcd),
    .digit_en(digit_en),
    .state(state),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: values held as plain integers, states as numbers.
  int m_state, m_set, m_rem, m_psc;
  bit m_done;
  int n_state, n_set, n_rem, n_psc;
  bit n_done;
  int win;

  always_comb begin
    n_state = m_state;
    n_set   = m_set;
    n_rem   = m_rem;
    n_psc   = m_psc;
    n_done  = 1'b0;
    if (key_clear)          win = 1;
    else if (key_confirm)   win = 2;
    else if (key_start)     win = 3;
    else if (key_num_valid) win = 4;
    else                    win = 0;
    case (m_state)
      0: if (win == 3) begin
        n_state = 1; n_set = 0; n_rem = 0;
      end
      1: begin
        if (win == 1) n_set = 0;
        else if (win == 2 && m_set != 0) begin
          n_state = 2; n_rem = m_set; n_psc = 0;
        end else if (win == 4 && key_num < 10)
          n_set = (m_set * 10 + int'(key_num)) % MOD;
      end
      2: begin
        if (win == 1) begin
          n_state = 1; n_set = 0; n_rem = 0;
        end else if (win == 3 && PAUSE) begin
          n_state = 4;
        end else if (m_psc == TD - 1) begin
          n_psc = 0;
          n_rem = m_rem - 1;
          if (n_rem == 0) begin
            n_state = 3; n_done = 1'b1;
          end
        end else begin
          n_psc = m_psc + 1;
        end
      end
      3: begin
        if (win == 1) begin
          n_state = 0; n_set = 0; n_rem = 0;
        end else if (win == 3) begin
          n_state = 1; n_set = 0; n_rem = 0;
        end
      end
      4: begin
        if (win == 1) begin
          n_state = 1; n_set = 0; n_rem = 0;
        end else if (win == 3) begin
          n_state = 2;
        end
      end
      default: ;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_set   <= 0;
      m_rem   <= 0;
      m_psc   <= 0;
      m_done  <= 1'b0;
    end else begin
      m_state <= n_state;
      m_set   <= n_set;
      m_rem   <= n_rem;
      m_psc   <= n_psc;
      m_done  <= n_done;
    end
  end

  always @(negedge clk) begin
    chk("m_state", 32'(state), 32'(m_state));
    chk("m_set", 32'(set_bcd), 32'(to_bcd(m_set)));
    chk("m_rem", 32'(rem_bcd), 32'(to_bcd(m_rem)));
    chk("m_en", 32'(digit_en), (m_state == 0) ? 32'd0 : 32'((1 << D) - 1));
    chk("m_done", 32'(done), 32'(m_done));
  end

  task automatic pulse(input bit c, input bit cf, input bit s,
                       input bit nv, input logic [3:0] k);
    key_clear     = c;
    key_confirm   = cf;
    key_start     = s;
    key_num_valid = nv;
    key_num       = k;
    @(negedge clk);
    key_clear     = 1'b0;
    key_confirm   = 1'b0;
    key_start     = 1'b0;
    key_num_valid = 1'b0;
    key_num       = 4'd0;
  endtask

  task automatic num(input logic [3:0] k);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, k);
  endtask

  initial begin
    rst_n = 1'b0;
    key_clear = 1'b0; key_confirm = 1'b0; key_start = 1'b0;
    key_num_valid = 1'b0; key_num = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(digit_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("start_state", 32'(state), 32'd1);
    chk("start_en", 32'(digit_en), 32'h3);
    num(4'd1); num(4'd2); num(4'd3); num(4'd11);
    chk("entry_set", 32'(set_bcd), 32'h23);
    chk("entry_state", 32'(state), 32'd1);

    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("clr_set", 32'(set_bcd), 32'h00);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("conf0_state", 32'(state), 32'd1);
    num(4'd0); num(4'd5);
    chk("set05", 32'(set_bcd), 32'h05);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("clrconf_set", 32'(set_bcd), 32'h00);
    chk("clrconf_state", 32'(state), 32'd1);

    num(4'd2); num(4'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("run_state", 32'(state), 32'd2);
    chk("run_rem", 32'(rem_bcd), 32'h21);
    repeat (3) @(negedge clk);
    chk("rem21_hold", 32'(rem_bcd), 32'h21);
    @(negedge clk);
    chk("rem20", 32'(rem_bcd), 32'h20);
    repeat (4) @(negedge clk);
    chk("rem19", 32'(rem_bcd), 32'h19);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("runclr_state", 32'(state), 32'd1);
    chk("runclr_rem", 32'(rem_bcd), 32'h00);

    num(4'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (3) @(negedge clk);
    chk("rem01", 32'(rem_bcd), 32'h01);
    chk("done_lo", 32'(done), 32'd0);
    @(negedge clk);
    chk("rem00", 32'(rem_bcd), 32'h00);
    chk("done_hi", 32'(done), 32'd1);
    chk("done_state", 32'(state), 32'd3);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("done_hold", 32'(state), 32'd3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_en", 32'(digit_en), 32'd0);

    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    num(4'd1); num(4'd5);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
`ifdef COUNTDOWN_PAUSE_EN
    chk("pause_state", 32'(state), 32'd4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("pause_rem", 32'(rem_bcd), 32'h15);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("resume_state", 32'(state), 32'd2);
`else
    chk("nopause_state", 32'(state), 32'd2);
`endif

    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_rem", 32'(rem_bcd), 32'h00);
    chk("arst_en", 32'(digit_en), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
